// File: rtl/codec_seq.sv
// codec_seq: power-up and mode-change sequencer for the audio codec front end.
// Drives ADC mode pins and PLL rate-select pins from a shadow configuration and keeps
// the DAC muted across every change until the clock has settled and LRCK is locked.
// Optional feature: define CODEC_SEQ_WATCHDOG_EN to keep watching LRCK while in RUN
// and drop to FAULT (muted) if it stops.
module codec_seq #(
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter int unsigned LOCK_FRAMES   = 4,
    parameter int unsigned LRCK_TIMEOUT  = 50000,
    parameter int unsigned MUTE_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_adc_lrck,
    input  logic       i_cfg_req,
    input  logic [2:0] i_cfg_adc,
    input  logic [3:0] i_cfg_pll,
    output logic       o_cfg_ack,
    output logic       o_adc_fmt,
    output logic       o_adc_md1,
    output logic       o_adc_md2,
    output logic       o_pll_csel,
    output logic       o_pll_fs1,
    output logic       o_pll_fs2,
    output logic       o_pll_sr,
    output logic       o_dac_nmute,
    output logic       o_ready,
    output logic       o_fault,
    output logic [2:0] o_state
);

    localparam logic [2:0] StApply  = 3'd0;
    localparam logic [2:0] StSettle = 3'd1;
    localparam logic [2:0] StLock   = 3'd2;
    localparam logic [2:0] StRun    = 3'd3;
    localparam logic [2:0] StMute   = 3'd4;
    localparam logic [2:0] StFault  = 3'd5;

    // Power-up pin defaults: {md2, md1, fmt} and {sr, fs2, fs1, csel}.
    localparam logic [2:0] AdcRst = 3'b110;
    localparam logic [3:0] PllRst = 4'b0000;

    // SETTLE and MUTE never overlap, so they share one dwell counter.
    localparam int unsigned CntMax = (SETTLE_CYCLES > MUTE_CYCLES) ? SETTLE_CYCLES
                                                                    : MUTE_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam int unsigned FrmW = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned GapW = $clog2(LRCK_TIMEOUT + 1);

    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] MuteLast   = CntW'(MUTE_CYCLES - 1);
    localparam logic [FrmW-1:0] FrmLast    = FrmW'(LOCK_FRAMES - 1);
    localparam logic [GapW-1:0] GapMax     = GapW'(LRCK_TIMEOUT);
    localparam logic [GapW-1:0] GapLast    = GapW'(LRCK_TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [FrmW-1:0] frm_q, frm_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            lrck_prev_q, lrck_prev_d;
    logic [2:0]      shadow_adc_q, shadow_adc_d;
    logic [3:0]      shadow_pll_q, shadow_pll_d;
    logic [2:0]      adc_pins_q, adc_pins_d;
    logic [3:0]      pll_pins_q, pll_pins_d;
    logic            nmute_q, nmute_d;
    logic            ready_q, ready_d;
    logic            fault_q, fault_d;
    logic            ack_q, ack_d;

    logic            lrck_edge;
    logic            gap_run;
    logic            timeout;
    logic            accept;
    logic            entering;

    // LRCK synchronizer and rising-edge detect.
    always_comb begin
        sync1_d     = i_adc_lrck;
        sync2_d     = sync1_q;
        lrck_prev_d = sync2_q;
        lrck_edge   = sync2_q & ~lrck_prev_q;
    end

    // Gap watch is live in LOCK, and in RUN as well when the watchdog is built in.
    always_comb begin
        gap_run = (state_q == StLock);
`ifdef CODEC_SEQ_WATCHDOG_EN
        if (state_q == StRun) begin
            gap_run = 1'b1;
        end
`endif
        // Timeout fires on the edge where the gap count reaches LRCK_TIMEOUT.
        timeout = gap_run && !lrck_edge && (gap_q >= GapLast);
    end

    // Next-state logic and request acceptance.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StApply: state_d = StSettle;
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StLock;
                end
            end
            StLock: begin
                // The final lock edge beats a coincident timeout.
                if (lrck_edge && (frm_q == FrmLast)) begin
                    state_d = StRun;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StRun: begin
                // A request beats a coincident watchdog timeout.
                if (i_cfg_req) begin
                    accept  = 1'b1;
                    state_d = StMute;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StMute: begin
                if (cnt_q == MuteLast) begin
                    state_d = StApply;
                end
            end
            StFault: begin
                // Already muted, so go straight to APPLY.
                if (i_cfg_req) begin
                    accept  = 1'b1;
                    state_d = StApply;
                end
            end
            default: state_d = StApply;
        endcase
    end

    // Dwell, frame and gap counters; all restart on every state entry.
    always_comb begin
        entering = (state_d != state_q);

        cnt_d = '0;
        if (!entering && ((state_q == StSettle) || (state_q == StMute))) begin
            cnt_d = cnt_q + 1'b1;
        end

        frm_d = frm_q;
        if (entering) begin
            frm_d = '0;
        end else if ((state_q == StLock) && lrck_edge) begin
            frm_d = frm_q + 1'b1;
        end

        gap_d = '0;
        if (!entering && gap_run && !lrck_edge && (gap_q != GapMax)) begin
            gap_d = gap_q + 1'b1;
        end else if (!entering && gap_run && !lrck_edge) begin
            gap_d = gap_q;
        end
    end

    // Shadow capture, pin drive and registered status outputs.
    always_comb begin
        shadow_adc_d = shadow_adc_q;
        shadow_pll_d = shadow_pll_q;
        if (accept) begin
            shadow_adc_d = i_cfg_adc;
            shadow_pll_d = i_cfg_pll;
        end

        // Pins only move on the edge leaving APPLY, when the DAC is muted.
        adc_pins_d = adc_pins_q;
        pll_pins_d = pll_pins_q;
        if (state_q == StApply) begin
            adc_pins_d = shadow_adc_q;
            pll_pins_d = shadow_pll_q;
        end

        nmute_d = (state_d == StRun);
        ready_d = (state_d == StRun);
        fault_d = (state_d == StFault);
        ack_d   = accept;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StApply;
            cnt_q        <= '0;
            frm_q        <= '0;
            gap_q        <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            lrck_prev_q  <= 1'b0;
            shadow_adc_q <= AdcRst;
            shadow_pll_q <= PllRst;
            adc_pins_q   <= AdcRst;
            pll_pins_q   <= PllRst;
            nmute_q      <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frm_q        <= frm_d;
            gap_q        <= gap_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            lrck_prev_q  <= lrck_prev_d;
            shadow_adc_q <= shadow_adc_d;
            shadow_pll_q <= shadow_pll_d;
            adc_pins_q   <= adc_pins_d;
            pll_pins_q   <= pll_pins_d;
            nmute_q      <= nmute_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            ack_q        <= ack_d;
        end
    end

    assign o_state     = state_q;
    assign o_cfg_ack   = ack_q;
    assign o_adc_fmt   = adc_pins_q[0];
    assign o_adc_md1   = adc_pins_q[1];
    assign o_adc_md2   = adc_pins_q[2];
    assign o_pll_csel  = pll_pins_q[0];
    assign o_pll_fs1   = pll_pins_q[1];
    assign o_pll_fs2   = pll_pins_q[2];
    assign o_pll_sr    = pll_pins_q[3];
    assign o_dac_nmute = nmute_q;
    assign o_ready     = ready_q;
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_codec_seq.sv
// tb_codec_seq: directed bench for codec_seq with short timing parameters.
// LRCK has a 40-cycle period; its rises land just after a clk edge so lock timing
// is exact. Watchdog expectations follow CODEC_SEQ_WATCHDOG_EN.
module tb_codec_seq;

    logic       clk;
    logic       rst_n;
    logic       lrck;
    logic       req;
    logic [2:0] cfg_adc;
    logic [3:0] cfg_pll;
    logic       o_cfg_ack;
    logic       o_adc_fmt, o_adc_md1, o_adc_md2;
    logic       o_pll_csel, o_pll_fs1, o_pll_fs2, o_pll_sr;
    logic       o_dac_nmute, o_ready, o_fault;
    logic [2:0] o_state;

    logic [2:0] adc_pins;
    logic [3:0] pll_pins;
    assign adc_pins = {o_adc_md2, o_adc_md1, o_adc_fmt};
    assign pll_pins = {o_pll_sr, o_pll_fs2, o_pll_fs1, o_pll_csel};

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int t0 = 0;
    int lrck_ph = 0;
    bit lrck_en = 0;

    codec_seq #(
        .SETTLE_CYCLES(8),
        .LOCK_FRAMES  (2),
        .LRCK_TIMEOUT (100),
        .MUTE_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_adc_lrck (lrck),
        .i_cfg_req  (req),
        .i_cfg_adc  (cfg_adc),
        .i_cfg_pll  (cfg_pll),
        .o_cfg_ack  (o_cfg_ack),
        .o_adc_fmt  (o_adc_fmt),
        .o_adc_md1  (o_adc_md1),
        .o_adc_md2  (o_adc_md2),
        .o_pll_csel (o_pll_csel),
        .o_pll_fs1  (o_pll_fs1),
        .o_pll_fs2  (o_pll_fs2),
        .o_pll_sr   (o_pll_sr),
        .o_dac_nmute(o_dac_nmute),
        .o_ready    (o_ready),
        .o_fault    (o_fault),
        .o_state    (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clk edge; inputs move 1 ns after it, outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (lrck_en) begin
            lrck_ph = (lrck_ph + 1) % 40;
            lrck    = (lrck_ph < 20);
        end else begin
            lrck = 1'b0;
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // t0 is the last edge with rst_n low; first LRCK rise lands after edge t0+1.
    task automatic do_reset(input bit lrck_on);
        lrck_en = 1'b0;
        req     = 1'b0;
        rst_n   = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        t0      = cyc;
        lrck_ph = 39;
        lrck_en = lrck_on;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        nvec++; if (o_state !== 3'd0) begin nerr++; $display("FAIL rst_state: got %0d want 0", o_state); end
        nvec++; if (adc_pins !== 3'b110) begin nerr++; $display("FAIL rst_adc: got %b want 110", adc_pins); end
        nvec++; if (pll_pins !== 4'b0000) begin nerr++; $display("FAIL rst_pll: got %b want 0000", pll_pins); end
        nvec++; if (o_dac_nmute !== 1'b0) begin nerr++; $display("FAIL rst_nmute: got %b want 0", o_dac_nmute); end
        nvec++; if (o_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", o_ready); end
        nvec++; if (o_fault !== 1'b0) begin nerr++; $display("FAIL rst_fault: got %b want 0", o_fault); end
        nvec++; if (o_cfg_ack !== 1'b0) begin nerr++; $display("FAIL rst_ack: got %b want 0", o_cfg_ack); end
    endtask

    task automatic test_power_up();
        do_reset(1'b1);
        run_to(t0 + 1);
        nvec++; if (o_state !== 3'd1) begin nerr++; $display("FAIL pwr_settle_in: got %0d want 1", o_state); end
        run_to(t0 + 8);
        nvec++; if (o_state !== 3'd1) begin nerr++; $display("FAIL pwr_settle_end: got %0d want 1", o_state); end
        run_to(t0 + 9);
        nvec++; if (o_state !== 3'd2) begin nerr++; $display("FAIL pwr_lock_in: got %0d want 2", o_state); end
        run_to(t0 + 83);
        nvec++; if ({o_state, o_dac_nmute} !== {3'd2, 1'b0}) begin
            nerr++; $display("FAIL pwr_pre_run: state/nmute got %0d/%b want 2/0", o_state, o_dac_nmute);
        end
        run_to(t0 + 84);
        nvec++; if ({o_state, o_dac_nmute, o_ready} !== {3'd3, 1'b1, 1'b1}) begin
            nerr++;
            $display("FAIL pwr_run: state/nmute/ready got %0d/%b/%b want 3/1/1",
                     o_state, o_dac_nmute, o_ready);
        end
    endtask

    // Continues from RUN reached at t0+84.
    task automatic test_mode_change();
        int a;
        run_to(t0 + 86);
        cfg_adc = 3'b100;
        cfg_pll = 4'b0010;
        req     = 1'b1;
        step();
        a = cyc;
        nvec++; if ({o_cfg_ack, o_state, o_dac_nmute, o_ready} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL mc_ack: ack/state/nmute/ready got %b/%0d/%b/%b want 1/4/0/0",
                     o_cfg_ack, o_state, o_dac_nmute, o_ready);
        end
        req = 1'b0;
        run_to(a + 1);
        nvec++; if (o_cfg_ack !== 1'b0) begin nerr++; $display("FAIL mc_ack_pulse: got %b want 0", o_cfg_ack); end
        run_to(a + 4);
        nvec++; if ({o_state, adc_pins, pll_pins} !== {3'd0, 3'b110, 4'b0000}) begin
            nerr++;
            $display("FAIL mc_apply: state/adc/pll got %0d/%b/%b want 0/110/0000",
                     o_state, adc_pins, pll_pins);
        end
        run_to(a + 5);
        nvec++; if ({o_state, adc_pins, pll_pins} !== {3'd1, 3'b100, 4'b0010}) begin
            nerr++;
            $display("FAIL mc_pins: state/adc/pll got %0d/%b/%b want 1/100/0010",
                     o_state, adc_pins, pll_pins);
        end
        run_to(t0 + 163);
        nvec++; if (o_state !== 3'd2) begin nerr++; $display("FAIL mc_relock: got %0d want 2", o_state); end
        run_to(t0 + 164);
        nvec++; if ({o_state, o_dac_nmute} !== {3'd3, 1'b1}) begin
            nerr++; $display("FAIL mc_run: state/nmute got %0d/%b want 3/1", o_state, o_dac_nmute);
        end
    endtask

    task automatic test_lrck_absent();
        do_reset(1'b0);
        run_to(t0 + 108);
        nvec++; if ({o_state, o_fault} !== {3'd2, 1'b0}) begin
            nerr++; $display("FAIL abs_pre_fault: state/fault got %0d/%b want 2/0", o_state, o_fault);
        end
        run_to(t0 + 109);
        nvec++; if ({o_state, o_fault, o_dac_nmute} !== {3'd5, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL abs_fault: state/fault/nmute got %0d/%b/%b want 5/1/0",
                     o_state, o_fault, o_dac_nmute);
        end
        run_to(t0 + 111);
        cfg_adc = 3'b001;
        cfg_pll = 4'b1000;
        req     = 1'b1;
        step();
        nvec++; if ({o_cfg_ack, o_state} !== {1'b1, 3'd0}) begin
            nerr++; $display("FAIL abs_ack: ack/state got %b/%0d want 1/0", o_cfg_ack, o_state);
        end
        req = 1'b0;
        step();
        nvec++; if ({o_state, adc_pins, pll_pins, o_cfg_ack, o_fault} !== {3'd1, 3'b001, 4'b1000, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL abs_apply: state/adc/pll/ack/fault got %0d/%b/%b/%b/%b want 1/001/1000/0/0",
                     o_state, adc_pins, pll_pins, o_cfg_ack, o_fault);
        end
    endtask

    task automatic test_early_request();
        bit early;
        do_reset(1'b1);
        run_to(t0 + 3);
        cfg_adc = 3'b010;
        cfg_pll = 4'b0100;
        req     = 1'b1;
        early   = 1'b0;
        while (cyc < t0 + 84) begin
            step();
            if (o_cfg_ack) early = 1'b1;
        end
        nvec++; if (early !== 1'b0) begin nerr++; $display("FAIL early_no_ack: ack seen=%b want 0", early); end
        nvec++; if (o_state !== 3'd3) begin nerr++; $display("FAIL early_run: got %0d want 3", o_state); end
        step();
        nvec++; if ({o_cfg_ack, o_state} !== {1'b1, 3'd4}) begin
            nerr++; $display("FAIL early_ack: ack/state got %b/%0d want 1/4", o_cfg_ack, o_state);
        end
        req = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset(1'b1);
        run_to(t0 + 84);
        nvec++; if (o_state !== 3'd3) begin nerr++; $display("FAIL wd_run: got %0d want 3", o_state); end
        lrck_en = 1'b0;
`ifdef CODEC_SEQ_WATCHDOG_EN
        run_to(t0 + 183);
        nvec++; if (o_state !== 3'd3) begin nerr++; $display("FAIL wd_pre: got %0d want 3", o_state); end
        run_to(t0 + 184);
        nvec++; if ({o_state, o_fault, o_dac_nmute} !== {3'd5, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL wd_fault: state/fault/nmute got %0d/%b/%b want 5/1/0",
                     o_state, o_fault, o_dac_nmute);
        end
`else
        run_to(t0 + 300);
        nvec++; if ({o_state, o_dac_nmute, o_fault} !== {3'd3, 1'b1, 1'b0}) begin
            nerr++;
            $display("FAIL wd_off_run: state/nmute/fault got %0d/%b/%b want 3/1/0",
                     o_state, o_dac_nmute, o_fault);
        end
`endif
    endtask

    task automatic test_reset_in_mute();
        do_reset(1'b1);
        run_to(t0 + 84);
        cfg_adc = 3'b000;
        cfg_pll = 4'b1111;
        req     = 1'b1;
        step();
        nvec++; if ({o_cfg_ack, o_state} !== {1'b1, 3'd4}) begin
            nerr++; $display("FAIL rm_ack: ack/state got %b/%0d want 1/4", o_cfg_ack, o_state);
        end
        req = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nvec++; if ({o_state, adc_pins, pll_pins, o_dac_nmute, o_ready, o_fault, o_cfg_ack} !==
                    {3'd0, 3'b110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL rm_reset: state/adc/pll/nmute/ready/fault/ack got %0d/%b/%b/%b/%b/%b/%b want 0/110/0000/0/0/0/0",
                     o_state, adc_pins, pll_pins, o_dac_nmute, o_ready, o_fault, o_cfg_ack);
        end
        step();
        nvec++; if ({o_state, adc_pins, pll_pins} !== {3'd1, 3'b110, 4'b0000}) begin
            nerr++;
            $display("FAIL rm_discard: state/adc/pll got %0d/%b/%b want 1/110/0000",
                     o_state, adc_pins, pll_pins);
        end
        step();
        step();
        nvec++; if ({adc_pins, pll_pins} !== {3'b110, 4'b0000}) begin
            nerr++; $display("FAIL rm_pins_hold: adc/pll got %b/%b want 110/0000", adc_pins, pll_pins);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        lrck    = 1'b0;
        req     = 1'b0;
        cfg_adc = 3'b000;
        cfg_pll = 4'b0000;
        test_reset();
        test_power_up();
        test_mode_change();
        test_lrck_absent();
        test_early_request();
        test_watchdog();
        test_reset_in_mute();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
